// File: rtl/int_fp_mul_pkg.sv
// +----------------------------------------------------------------------------+
// | int_fp_mul_pkg : FP16 field layout, constants and helpers shared by the    |
// |                  INT8/FP16 multiplier. Optional macro: FP_SUBNORMAL_EN.    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package int_fp_mul_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  typedef enum logic {
    MODE_INT = 1'b0,
    MODE_FP  = 1'b1
  } mode_e;

  // Leading-zero count of a 10-bit fraction (10 when all zero).
  function automatic logic [3:0] lzc10(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) n = 4'(9 - i);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_fp_mul_unit_fp16_round_pack.sv
// +----------------------------------------------------------------------------+
// | fp16_round_pack : RNE rounding, overflow/underflow detection and packing   |
// |                   of an FP16 product. Optional macro: FP_SUBNORMAL_EN.     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp16_round_pack
  import int_fp_mul_pkg::*;
(
  input  logic              sign,
  input  logic signed [7:0] exp_in,
  input  logic [10:0]       sig,
  input  logic              guard,
  input  logic              sticky,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic              w_inc;
  logic [11:0]       w_sum;
  logic signed [7:0] w_exp_rnd;
  logic              w_tiny;

  assign w_inc = guard & (sticky | sig[0]);
  assign w_sum = {1'b0, sig} + {11'd0, w_inc};
  // w_sum[11:10] is 2'b01 without a rounding carry and 2'b10 with one.
  assign w_exp_rnd = exp_in - 8'sd1 + $signed({6'd0, w_sum[11:10]});
  assign w_tiny    = (w_exp_rnd < 8'sd1);

`ifdef FP_SUBNORMAL_EN
  logic [3:0]  w_shamt;
  logic [25:0] w_sh;
  logic        w_sub_g;
  logic        w_sub_st;
  logic        w_sub_inc;
  logic [10:0] w_sub_sum;

  // Shifts beyond 13 leave only sticky, so clamp there.
  assign w_shamt   = (exp_in < -8'sd12) ? 4'd13 : (4'd1 - exp_in[3:0]);
  assign w_sh      = {sig, guard, 14'd0} >> w_shamt;
  assign w_sub_g   = w_sh[14];
  assign w_sub_st  = (|w_sh[13:0]) | sticky;
  assign w_sub_inc = w_sub_g & (w_sub_st | w_sh[15]);
  assign w_sub_sum = w_sh[25:15] + {10'd0, w_sub_inc};
`endif

  always_comb begin
    result    = {sign, w_exp_rnd[4:0], w_sum[9:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (!w_tiny) begin
      if (w_exp_rnd >= 8'sd31) begin
        result   = POS_INF | {sign, 15'd0};
        overflow = 1'b1;
      end
    end else begin
`ifdef FP_SUBNORMAL_EN
      // A carry into bit 10 lands on the minimum normal encoding.
      result    = {sign, 4'd0, w_sub_sum};
      underflow = w_sub_g | w_sub_st;
`else
      result    = {sign, 15'd0};
      underflow = 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_fp_mul_unit.sv
// +----------------------------------------------------------------------------+
// | int_fp_mul_unit : dual-mode FP16 / signed INT8 multiplier, 1-cycle latency.|
// |                   Optional macro: FP_SUBNORMAL_EN (gradual underflow).     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module int_fp_mul_unit
  import int_fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mode,
  input  logic [15:0] input1,
  input  logic [15:0] input2,
  output logic        out_valid,
  output logic [15:0] result,
  output logic        overflow,
  output logic        underflow
);

  fp16_t             w_a, w_b;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic [10:0]       w_sig_a, w_sig_b;
  logic signed [7:0] w_exp_a, w_exp_b;
  logic [7:0]        w_mag_a, w_mag_b;
  logic [10:0]       w_mul_a, w_mul_b;
  logic [21:0]       w_prod;
  logic              w_fp_sign, w_norm;
  logic [15:0]       w_int_res;
  logic [10:0]       w_fp_sig;
  logic              w_fp_guard, w_fp_sticky;
  logic signed [7:0] w_fp_exp;
  logic [15:0]       w_rp_result;
  logic              w_rp_ovf, w_rp_unf;
  logic [15:0]       w_res;
  logic              w_ovf, w_unf;
  logic              r_out_valid, r_ovf, r_unf;
  logic [15:0]       r_result;

  assign w_a = fp16_t'(input1);
  assign w_b = fp16_t'(input2);

  assign w_nan_a = (w_a.exp == '1) && (w_a.man != '0);
  assign w_nan_b = (w_b.exp == '1) && (w_b.man != '0);
  assign w_inf_a = (w_a.exp == '1) && (w_a.man == '0);
  assign w_inf_b = (w_b.exp == '1) && (w_b.man == '0);
`ifdef FP_SUBNORMAL_EN
  assign w_zero_a = (w_a.exp == '0) && (w_a.man == '0);
  assign w_zero_b = (w_b.exp == '0) && (w_b.man == '0);
`else
  assign w_zero_a = (w_a.exp == '0);
  assign w_zero_b = (w_b.exp == '0);
`endif

  always_comb begin
    w_sig_a = {1'b1, w_a.man};
    w_exp_a = {3'b000, w_a.exp};
    w_sig_b = {1'b1, w_b.man};
    w_exp_b = {3'b000, w_b.exp};
`ifdef FP_SUBNORMAL_EN
    // Subnormals are pre-normalised so the product stays in [1,4).
    if (w_a.exp == '0) begin
      w_sig_a = {1'b0, w_a.man} << (lzc10(w_a.man) + 4'd1);
      w_exp_a = 8'sd0 - $signed({4'd0, lzc10(w_a.man)});
    end
    if (w_b.exp == '0) begin
      w_sig_b = {1'b0, w_b.man} << (lzc10(w_b.man) + 4'd1);
      w_exp_b = 8'sd0 - $signed({4'd0, lzc10(w_b.man)});
    end
`endif
  end

  // INT8 path reuses the significand multiplier on magnitudes.
  assign w_mag_a = input1[7] ? (8'd0 - input1[7:0]) : input1[7:0];
  assign w_mag_b = input2[7] ? (8'd0 - input2[7:0]) : input2[7:0];
  assign w_mul_a = (mode_e'(mode) == MODE_FP) ? w_sig_a : {3'd0, w_mag_a};
  assign w_mul_b = (mode_e'(mode) == MODE_FP) ? w_sig_b : {3'd0, w_mag_b};
  assign w_prod  = {11'd0, w_mul_a} * {11'd0, w_mul_b};

  assign w_int_res = (input1[7] ^ input2[7]) ? (16'd0 - w_prod[15:0]) : w_prod[15:0];

  assign w_fp_sign   = w_a.sign ^ w_b.sign;
  assign w_norm      = w_prod[21];
  assign w_fp_sig    = w_norm ? w_prod[21:11] : w_prod[20:10];
  assign w_fp_guard  = w_norm ? w_prod[10] : w_prod[9];
  assign w_fp_sticky = w_norm ? (|w_prod[9:0]) : (|w_prod[8:0]);
  assign w_fp_exp    = w_exp_a + w_exp_b - 8'(BIAS) + {7'd0, w_norm};

  fp16_round_pack u_round_pack (
    .sign      (w_fp_sign),
    .exp_in    (w_fp_exp),
    .sig       (w_fp_sig),
    .guard     (w_fp_guard),
    .sticky    (w_fp_sticky),
    .result    (w_rp_result),
    .overflow  (w_rp_ovf),
    .underflow (w_rp_unf)
  );

  always_comb begin
    w_res = w_rp_result;
    w_ovf = w_rp_ovf;
    w_unf = w_rp_unf;
    if (mode_e'(mode) == MODE_INT) begin
      w_res = w_int_res;
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end else if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
      w_res = QNAN;
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end else if (w_inf_a || w_inf_b) begin
      w_res = POS_INF | {w_fp_sign, 15'd0};
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end else if (w_zero_a || w_zero_b) begin
      w_res = {w_fp_sign, 15'd0};
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= 16'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_int_fp_mul_unit.sv
// +----------------------------------------------------------------------------+
// | tb_int_fp_mul_unit : directed self-checking bench for int_fp_mul_unit.     |
// |                      Honours FP_SUBNORMAL_EN for underflow expectations.   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_int_fp_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        mode;
  logic [15:0] input1;
  logic [15:0] input2;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_fp_mul_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mode      (mode),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mode     = m;
    input1   = a;
    input2   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res,
                            input logic ov, input logic uf);
    chk({tag, ".result"}, result, res);
    chk({tag, ".ovf"}, {15'd0, overflow}, {15'd0, ov});
    chk({tag, ".unf"}, {15'd0, underflow}, {15'd0, uf});
    chk({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    input1   = 16'd0;
    input2   = 16'd0;
    #12;
    chk("rst.result", result, 16'd0);
    chk("rst.ovf", {15'd0, overflow}, 16'd0);
    chk("rst.unf", {15'd0, underflow}, 16'd0);
    chk("rst.valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // FP basic
    drive(1'b1, 16'h3C00, 16'h4000); expect_out("fp_1x2", 16'h4000, 1'b0, 1'b0);
    drive(1'b1, 16'h3E00, 16'h3E00); expect_out("fp_1p5sq", 16'h4080, 1'b0, 1'b0);
    drive(1'b1, 16'hBC00, 16'h4000); expect_out("fp_neg", 16'hC000, 1'b0, 1'b0);

    // FP specials
    drive(1'b1, 16'h7C00, 16'h0000); expect_out("fp_infx0", 16'h7E00, 1'b0, 1'b0);
    drive(1'b1, 16'hFC00, 16'h3C00); expect_out("fp_ninf", 16'hFC00, 1'b0, 1'b0);
    drive(1'b1, 16'h7E01, 16'h3C00); expect_out("fp_nan", 16'h7E00, 1'b0, 1'b0);
    drive(1'b1, 16'h8000, 16'h3C00); expect_out("fp_nzero", 16'h8000, 1'b0, 1'b0);

    // FP overflow and rounding
    drive(1'b1, 16'h7BFF, 16'h7BFF); expect_out("fp_ovf", 16'h7C00, 1'b1, 1'b0);
    drive(1'b1, 16'h3C01, 16'h3C01); expect_out("fp_rne", 16'h3C02, 1'b0, 1'b0);

    // Tiny results; 0x1DA8*0x21A8 rounds up onto the minimum normal
    drive(1'b1, 16'h1DA8, 16'h21A8); expect_out("fp_to_minnorm", 16'h0400, 1'b0, 1'b0);
`ifdef FP_SUBNORMAL_EN
    drive(1'b1, 16'h0400, 16'h3800); expect_out("fp_unf_exact", 16'h0200, 1'b0, 1'b0);
    drive(1'b1, 16'h0401, 16'h3800); expect_out("fp_unf_tie", 16'h0200, 1'b0, 1'b1);
    drive(1'b1, 16'h0001, 16'h3C00); expect_out("fp_sub_in", 16'h0001, 1'b0, 1'b0);
`else
    drive(1'b1, 16'h0400, 16'h3800); expect_out("fp_unf_exact", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 16'h0401, 16'h3800); expect_out("fp_unf_tie", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 16'h0001, 16'h3C00); expect_out("fp_sub_in", 16'h0000, 1'b0, 1'b0);
`endif

    // INT8: -3*7, -128*-128, 127*-127 with junk upper bytes, -1*-1
    drive(1'b0, 16'h00FD, 16'h0007); expect_out("int_neg", 16'hFFEB, 1'b0, 1'b0);
    drive(1'b0, 16'h0080, 16'h0080); expect_out("int_min", 16'h4000, 1'b0, 1'b0);
    drive(1'b0, 16'hAB7F, 16'h1281); expect_out("int_hi_ign", 16'hC0FF, 1'b0, 1'b0);
    drive(1'b0, 16'h00FF, 16'h00FF); expect_out("int_m1sq", 16'h0001, 1'b0, 1'b0);

    // Idle cycle: result holds, out_valid drops
    @(negedge clk);
    in_valid = 1'b0;
    mode     = 1'b1;
    input1   = 16'h3C00;
    input2   = 16'h3C00;
    @(posedge clk);
    #1;
    chk("hold.result", result, 16'h0001);
    chk("hold.valid", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset while a new operand pair is presented
    drive(1'b1, 16'h3C00, 16'h4000);
    @(negedge clk);
    input1   = 16'h3E00;
    input2   = 16'h3E00;
    in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.result", result, 16'd0);
    chk("arst.valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk("arst_edge.result", result, 16'd0);
    chk("arst_edge.valid", {15'd0, out_valid}, 16'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    drive(1'b1, 16'hBC00, 16'h3E00); expect_out("post_rst", 16'hBE00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
